replay_guard_rx: RTL and testbench
==================================

# replay_guard_rx

Receive-side replay filter for the protected serial link. Consumes the byte stream from `uart_rx` as two-byte frames (sequence byte, then payload byte), accepts a frame only if its sequence number lies within a forward window of the expected value, and queues accepted payloads in an internal first-word-fall-through buffer for the application. Rejected frames raise `replay_error`; stalled frames are abandoned on timeout.

## Interface
- `DEPTH`, 8: payload buffer entries (power of two, ≥2)
- `WINDOW`, 4: accepted forward distance, 1..128
- `TIMEOUT`, 1024: idle cycles in `WAIT_DATA` before the frame is abandoned
- `clk_3125` in 1: system clock
- `reset` in 1: asynchronous, active-high reset
- `rx_msg` in 8: received byte, valid when `rx_complete` is high
- `rx_complete` in 1: one-cycle strobe per received byte
- `read_en` in 1: pop head of payload buffer; ignored when `empty`
- `data_out` out 8: head of payload buffer (FWFT); 0 when empty
- `empty` out 1: buffer holds no entries
- `full` out 1: buffer holds `DEPTH` entries
- `replay_error` out 1: one-cycle pulse, frame rejected by sequence check
- `overflow` out 1: one-cycle pulse, accepted payload lost because buffer full
- `frame_error` out 1: one-cycle pulse, frame abandoned on timeout
- `drop_count` out 8: rejected + overflowed + timed-out frames, saturates at 255
- `seq_expected` out 8: next expected sequence number

## Operation
- States: `WAIT_SEQ`, `WAIT_DATA`, `COMMIT`. Reset state `WAIT_SEQ`.
- `WAIT_SEQ`: on `rx_complete`, latch `rx_msg` as S, clear timeout counter, go `WAIT_DATA`.
- `WAIT_DATA`: on `rx_complete`, latch `rx_msg` as payload, go `COMMIT`. Otherwise increment timeout counter; when it reaches `TIMEOUT`, pulse `frame_error`, increment `drop_count`, go `WAIT_SEQ`, `seq_expected` unchanged.
- `COMMIT` (exactly one cycle, always returns to `WAIT_SEQ`):
  - diff = (S − `seq_expected`) mod 256, 8-bit unsigned.
  - diff < `WINDOW`: accept; `seq_expected` ← S+1 mod 256 (skipped numbers are forfeited). Push payload unless buffer full and no simultaneous pop; in that case pulse `overflow`, increment `drop_count`, `seq_expected` still advances.
  - diff ≥ `WINDOW` (includes duplicates and old numbers): pulse `replay_error`, increment `drop_count`, no push, `seq_expected` unchanged.
  - `rx_complete` during `COMMIT` is latched as the next S and the FSM goes to `WAIT_DATA` instead of `WAIT_SEQ`.
- Buffer: circular, pointers wrap at `DEPTH`, occupancy counter 0..`DEPTH`. Push and pop in the same cycle: both occur, occupancy unchanged (allowed even when full or, for pop, ignored when empty). Pop on empty is a no-op.
- `drop_count` never wraps; it holds 255 once reached.

## Timing
- Reset values: `data_out`=0, `empty`=1, `full`=0, `replay_error`=0, `overflow`=0, `frame_error`=0, `drop_count`=0, `seq_expected`=0, pointers and occupancy 0, timeout counter 0.
- Reset asserted mid-frame discards the partial frame and all buffered payloads immediately (asynchronous).
- Payload `rx_complete` sampled at edge N → `COMMIT` during cycle N..N+1 → push, flags and `seq_expected` update at edge N+1 → `empty` low and `data_out` valid after edge N+1.
- Error pulses are registered, high for exactly the cycle after edge N+1.
- `read_en` at edge M: `data_out` shows the next entry (or 0, `empty`=1) after edge M.
- `full`/`empty` are registered from the updated occupancy, no extra latency.

## Test plan
- After reset send frames (0,0xA5),(1,0x3C) → `data_out`=0xA5 then 0x3C on pops, `seq_expected`=2, no error pulses, `drop_count`=0.
- Replay (1,0x3C) after the above → `replay_error` one cycle, buffer unchanged, `drop_count`=1, `seq_expected`=2.
- Send S=5 with `seq_expected`=2, `WINDOW`=4 → accepted, `seq_expected`=6; then S=10 → rejected; wrap case `seq_expected`=254, S=1 → accepted (diff 3), `seq_expected`=2.
- Push 8 accepted frames without reading, then a 9th → `full`=1, `overflow` pulse, `drop_count`+1, `seq_expected` advanced; 9th with `read_en` in the commit cycle → pushed, no overflow.
- Send sequence byte only, idle 1024 cycles → `frame_error` one cycle, state `WAIT_SEQ`, next full frame accepted normally.
- Assert `reset` between sequence and payload bytes with 3 entries buffered → `empty`=1, `seq_expected`=0 immediately; following frame (0,0x11) accepted.

Source files
------------

// File: rtl/replay_guard_rx.sv
// replay_guard_rx
//   Receive-side replay filter. Groups the uart_rx byte stream into
//   (sequence, payload) frames, accepts a frame only when its sequence number
//   lies within WINDOW ahead of the expected value, and queues accepted
//   payloads in a first-word-fall-through buffer.
// Ports:
//   clk_3125, reset          clock, async active-high reset
//   rx_msg, rx_complete      received byte + one-cycle strobe
//   read_en                  pop head of payload buffer (ignored when empty)
//   data_out, empty, full    FWFT head (0 when empty) and occupancy flags
//   replay_error, overflow,
//   frame_error              one-cycle error pulses
//   drop_count               saturating count of dropped frames
//   seq_expected             next expected sequence number
module replay_guard_rx #(
  parameter int DEPTH   = 8,
  parameter int WINDOW  = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic       clk_3125,
  input  logic       reset,
  input  logic [7:0] rx_msg,
  input  logic       rx_complete,
  input  logic       read_en,
  output logic [7:0] data_out,
  output logic       empty,
  output logic       full,
  output logic       replay_error,
  output logic       overflow,
  output logic       frame_error,
  output logic [7:0] drop_count,
  output logic [7:0] seq_expected
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [8:0]    WIN  = 9'(WINDOW);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [TW-1:0] TOUT = TW'(TIMEOUT);

  typedef enum logic [1:0] {WAIT_SEQ, WAIT_DATA, COMMIT} state_t;

  state_t        state;
  logic [7:0]    seq_byte;
  logic [7:0]    payload;
  logic [TW-1:0] tcnt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;

  logic [7:0]    diff;
  logic          in_window, commit, accept, reject;
  logic          pop, push, ovf, timeout_hit, drop;
  logic [TW-1:0] tcnt_next;
  logic [CW-1:0] count_next;

  // Modular distance ahead of the expected number; duplicates and old
  // numbers land at the top of the 8-bit range and fall outside the window.
  assign diff      = seq_byte - seq_expected;
  assign in_window = {1'b0, diff} < WIN;
  assign commit    = (state == COMMIT);
  assign accept    = commit && in_window;
  assign reject    = commit && !in_window;

  // A pop in the commit cycle frees a slot, so a full buffer still accepts.
  assign pop  = read_en && !empty;
  assign push = accept && (!full || pop);
  assign ovf  = accept && full && !pop;

  assign tcnt_next   = tcnt + 1'b1;
  assign timeout_hit = (state == WAIT_DATA) && !rx_complete && (tcnt_next == TOUT);
  assign drop        = reject || ovf || timeout_hit;

  assign count_next = count + CW'(push) - CW'(pop);

  assign data_out = empty ? 8'h00 : mem[rd_ptr];

  // Storage needs no reset: data_out is masked while empty.
  always_ff @(posedge clk_3125) begin
    if (push) mem[wr_ptr] <= payload;
  end

  always_ff @(posedge clk_3125 or posedge reset) begin
    if (reset) begin
      state        <= WAIT_SEQ;
      seq_byte     <= 8'h00;
      payload      <= 8'h00;
      tcnt         <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      empty        <= 1'b1;
      full         <= 1'b0;
      replay_error <= 1'b0;
      overflow     <= 1'b0;
      frame_error  <= 1'b0;
      drop_count   <= 8'h00;
      seq_expected <= 8'h00;
    end else begin
      replay_error <= reject;
      overflow     <= ovf;
      frame_error  <= timeout_hit;

      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'h01;
      if (accept) seq_expected <= seq_byte + 8'h01;

      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == FULL);

      case (state)
        WAIT_SEQ: begin
          if (rx_complete) begin
            seq_byte <= rx_msg;
            tcnt     <= '0;
            state    <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (rx_complete) begin
            payload <= rx_msg;
            state   <= COMMIT;
          end else if (timeout_hit) begin
            tcnt  <= '0;
            state <= WAIT_SEQ;
          end else begin
            tcnt <= tcnt_next;
          end
        end
        COMMIT: begin
          // A byte arriving during commit already starts the next frame.
          if (rx_complete) begin
            seq_byte <= rx_msg;
            tcnt     <= '0;
            state    <= WAIT_DATA;
          end else begin
            state <= WAIT_SEQ;
          end
        end
        default: state <= WAIT_SEQ;
      endcase
    end
  end

endmodule

// File: tb/tb_replay_guard_rx.sv
// Directed bench for replay_guard_rx (default parameters).
// All tasks enter and leave 1 ns after a rising edge; outputs are checked there.
module tb_replay_guard_rx;

  logic       clk_3125 = 1'b0;
  logic       reset;
  logic [7:0] rx_msg;
  logic       rx_complete;
  logic       read_en;
  logic [7:0] data_out;
  logic       empty, full, replay_error, overflow, frame_error;
  logic [7:0] drop_count, seq_expected;

  int tests = 0;
  int fails = 0;

  replay_guard_rx dut (
    .clk_3125     (clk_3125),
    .reset        (reset),
    .rx_msg       (rx_msg),
    .rx_complete  (rx_complete),
    .read_en      (read_en),
    .data_out     (data_out),
    .empty        (empty),
    .full         (full),
    .replay_error (replay_error),
    .overflow     (overflow),
    .frame_error  (frame_error),
    .drop_count   (drop_count),
    .seq_expected (seq_expected)
  );

  always #5 clk_3125 = ~clk_3125;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_3125); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_msg = b; rx_complete = 1'b1;
    step();
    rx_complete = 1'b0;
  endtask

  // Leaves the bench right after the commit edge, where pulses are visible.
  task automatic frame(input logic [7:0] s, input logic [7:0] p);
    send_byte(s);
    send_byte(p);
    step();
  endtask

  task automatic pop();
    read_en = 1'b1;
    step();
    read_en = 1'b0;
  endtask

  logic [7:0] e, s;
  logic [7:0] exp_q [9];

  initial begin
    reset = 1'b1; rx_msg = 8'h00; rx_complete = 1'b0; read_en = 1'b0;
    repeat (3) @(posedge clk_3125);
    #1;
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_seq", 32'(seq_expected), 0);
    chk("rst_drop", 32'(drop_count), 0);
    chk("rst_flags", 32'({replay_error, overflow, frame_error}), 0);
    reset = 1'b0;
    step();

    // In-order frames
    frame(8'd0, 8'hA5);
    chk("f0_data", 32'(data_out), 32'hA5);
    chk("f0_empty", 32'(empty), 0);
    chk("f0_seq", 32'(seq_expected), 1);
    frame(8'd1, 8'h3C);
    chk("f1_seq", 32'(seq_expected), 2);
    chk("f1_flags", 32'({replay_error, overflow, frame_error}), 0);
    chk("f1_drop", 32'(drop_count), 0);

    // Replay of frame 1
    frame(8'd1, 8'h3C);
    chk("rep_pulse", 32'(replay_error), 1);
    chk("rep_drop", 32'(drop_count), 1);
    chk("rep_seq", 32'(seq_expected), 2);
    step();
    chk("rep_pulse_end", 32'(replay_error), 0);

    // Drain in order
    chk("pop_head0", 32'(data_out), 32'hA5);
    pop();
    chk("pop_head1", 32'(data_out), 32'h3C);
    pop();
    chk("pop_empty", 32'(empty), 1);
    chk("pop_zero", 32'(data_out), 0);
    pop();
    chk("pop_on_empty", 32'(empty), 1);

    // Forward skip inside window, then one just outside
    frame(8'd5, 8'h77);
    chk("skip_seq", 32'(seq_expected), 6);
    chk("skip_err", 32'(replay_error), 0);
    chk("skip_data", 32'(data_out), 32'h77);
    frame(8'd10, 8'h88);
    chk("win_edge_rej", 32'(replay_error), 1);
    chk("win_edge_seq", 32'(seq_expected), 6);
    chk("win_edge_drop", 32'(drop_count), 2);
    pop();

    // Walk seq_expected up to 254 in steps of 4, then wrap
    e = 8'd6;
    while (e != 8'd254) begin
      s = e + 8'd3;
      frame(s, s);
      pop();
      e = s + 8'd1;
    end
    chk("walk_seq", 32'(seq_expected), 254);
    chk("walk_empty", 32'(empty), 1);
    frame(8'd1, 8'h42);
    chk("wrap_err", 32'(replay_error), 0);
    chk("wrap_seq", 32'(seq_expected), 2);
    chk("wrap_data", 32'(data_out), 32'h42);
    pop();

    // Fill, overflow, then accept into a full buffer with a same-cycle pop
    for (int i = 0; i < 8; i++) frame(8'(2 + i), 8'(8'h50 + i));
    chk("fill_full", 32'(full), 1);
    chk("fill_seq", 32'(seq_expected), 10);
    frame(8'd10, 8'h99);
    chk("ovf_pulse", 32'(overflow), 1);
    chk("ovf_drop", 32'(drop_count), 3);
    chk("ovf_seq", 32'(seq_expected), 11);
    chk("ovf_full", 32'(full), 1);
    step();
    chk("ovf_pulse_end", 32'(overflow), 0);
    send_byte(8'd11);
    send_byte(8'h9A);
    read_en = 1'b1;
    step();
    read_en = 1'b0;
    chk("fullpop_ovf", 32'(overflow), 0);
    chk("fullpop_full", 32'(full), 1);
    chk("fullpop_seq", 32'(seq_expected), 12);
    chk("fullpop_drop", 32'(drop_count), 3);
    for (int i = 0; i < 7; i++) exp_q[i] = 8'(8'h51 + i);
    exp_q[7] = 8'h9A;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("drain%0d", i), 32'(data_out), 32'(exp_q[i]));
      pop();
    end
    chk("drain_empty", 32'(empty), 1);

    // Timeout after a lone sequence byte
    send_byte(8'd12);
    repeat (1023) step();
    chk("to_early", 32'(frame_error), 0);
    step();
    chk("to_pulse", 32'(frame_error), 1);
    chk("to_drop", 32'(drop_count), 4);
    chk("to_seq", 32'(seq_expected), 12);
    step();
    chk("to_pulse_end", 32'(frame_error), 0);
    frame(8'd12, 8'h66);
    chk("to_next_seq", 32'(seq_expected), 13);
    chk("to_next_data", 32'(data_out), 32'h66);

    // Asynchronous reset mid-frame with 3 entries buffered
    frame(8'd13, 8'h01);
    frame(8'd14, 8'h02);
    send_byte(8'd15);
    #2 reset = 1'b1;
    #1;
    chk("ar_empty", 32'(empty), 1);
    chk("ar_seq", 32'(seq_expected), 0);
    chk("ar_data", 32'(data_out), 0);
    #2 reset = 1'b0;
    step();
    frame(8'd0, 8'h11);
    chk("ar_next_seq", 32'(seq_expected), 1);
    chk("ar_next_data", 32'(data_out), 32'h11);
    chk("ar_next_err", 32'(replay_error), 0);

    // drop_count saturation: 260 duplicates of sequence 0
    for (int i = 0; i < 260; i++) frame(8'd0, 8'hEE);
    chk("sat_drop", 32'(drop_count), 255);
    chk("sat_seq", 32'(seq_expected), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
